// File: rtl/quant_arbiter.sv
// Round-robin arbiter that lends one fixed-latency quantizer to NUM_REQ requesters, one owner burst at a time.
// Accept-to-response latency is 2+QUANT_LATENCY; only the owner sees req_ready, and only for up to MAX_BURST beats.
module quant_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int IDATA_WIDTH       = 24,
  parameter int ODATA_BIT         = 8,
  parameter int CDATA_SCALE_WIDTH = 16,
  parameter int CDATA_BIAS_WIDTH  = 16,
  parameter int CDATA_SHIFT_WIDTH = 5,
  parameter int QUANT_LATENCY     = 5,
  parameter int MAX_BURST         = 16
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           cfg_wr_en,
  input  logic [$clog2(NUM_REQ)-1:0]     cfg_wr_idx,
  input  logic [CDATA_SCALE_WIDTH-1:0]   cfg_wr_scale,
  input  logic [CDATA_BIAS_WIDTH-1:0]    cfg_wr_bias,
  input  logic [CDATA_SHIFT_WIDTH-1:0]   cfg_wr_shift,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*IDATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [IDATA_WIDTH-1:0]         q_idata,
  output logic                           q_idata_valid,
  output logic [CDATA_SCALE_WIDTH-1:0]   q_scale,
  output logic [CDATA_BIAS_WIDTH-1:0]    q_bias,
  output logic [CDATA_SHIFT_WIDTH-1:0]   q_shift,
  input  logic [ODATA_BIT-1:0]           q_odata,
  input  logic                           q_odata_valid,
  output logic [ODATA_BIT-1:0]           rsp_data,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]     owner,
  output logic                           busy,
  output logic                           err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int FW = $clog2(QUANT_LATENCY + 2);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t                         state;
  logic [IW-1:0]                  last_owner;
  logic [IW-1:0]                  pick;
  logic [IW-1:0]                  cand;
  logic                           pick_vld;
  logic [BW-1:0]                  beat_cnt;
  logic [FW-1:0]                  inflight;
  logic                           accept;
  logic                           last_beat;
  logic [IDATA_WIDTH-1:0]         owner_data;
  logic [CDATA_SCALE_WIDTH-1:0]   tbl_scale [NUM_REQ];
  logic [CDATA_BIAS_WIDTH-1:0]    tbl_bias  [NUM_REQ];
  logic [CDATA_SHIFT_WIDTH-1:0]   tbl_shift [NUM_REQ];

  // Search starts one past the previous owner so a lone requester wraps back to itself.
  always_comb begin
    pick     = last_owner;
    cand     = last_owner;
    pick_vld = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_owner) + k) % NUM_REQ);
      if (!pick_vld && req_valid[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == owner) owner_data = req_data[i*IDATA_WIDTH +: IDATA_WIDTH];
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == BURST && beat_cnt < BW'(MAX_BURST)) req_ready[owner] = 1'b1;
  end

  assign accept    = req_valid[owner] && req_ready[owner];
  assign last_beat = (beat_cnt == BW'(MAX_BURST - 1));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        tbl_scale[i] <= '0;
        tbl_bias[i]  <= '0;
        tbl_shift[i] <= '0;
      end
    end else if (cfg_wr_en) begin
      tbl_scale[cfg_wr_idx] <= cfg_wr_scale;
      tbl_bias[cfg_wr_idx]  <= cfg_wr_bias;
      tbl_shift[cfg_wr_idx] <= cfg_wr_shift;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      owner         <= '0;
      last_owner    <= IW'(NUM_REQ - 1);
      beat_cnt      <= '0;
      q_idata       <= '0;
      q_idata_valid <= 1'b0;
      q_scale       <= '0;
      q_bias        <= '0;
      q_shift       <= '0;
    end else begin
      q_idata_valid <= accept;
      if (accept) begin
        q_idata  <= owner_data;
        beat_cnt <= beat_cnt + BW'(1);
      end
      case (state)
        IDLE: if (pick_vld) begin
          owner    <= pick;
          q_scale  <= tbl_scale[pick];
          q_bias   <= tbl_bias[pick];
          q_shift  <= tbl_shift[pick];
          beat_cnt <= '0;
          state    <= BURST;
        end
        BURST: if (!req_valid[owner] || (accept && last_beat)) state <= DRAIN;
        // The beat registered on the last BURST cycle is not yet counted in inflight.
        DRAIN: if (inflight == '0 && !q_idata_valid) begin
          state      <= IDLE;
          last_owner <= owner;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight  <= '0;
      err       <= 1'b0;
      rsp_data  <= '0;
      rsp_valid <= '0;
    end else begin
      case ({q_idata_valid, q_odata_valid})
        2'b10: inflight <= inflight + FW'(1);
        2'b01: begin
          if (inflight != '0) inflight <= inflight - FW'(1);
          else                err      <= 1'b1;
        end
        default: ;
      endcase
      rsp_valid <= q_odata_valid ? (NUM_REQ'(1) << owner) : '0;
      if (q_odata_valid) rsp_data <= q_odata;
    end
  end

endmodule
